// File: rtl/rst_seq.sv
// Power-on reset sequencer: waits for stable clock locks, releases DDR2, waits for
// calibration, then releases the Wishbone fabric and each CPU core in staged order.
module rst_seq #(
    parameter int unsigned NUM_CORES          = 2,
    parameter int unsigned LOCK_STABLE_CYCLES = 1024,
    parameter int unsigned STAGE_DELAY        = 16,
    parameter int unsigned CALIB_TIMEOUT      = 65535
) (
    input  logic                 wb_clk_i,
    input  logic                 async_rst_n_i,
    input  logic                 pll_locked_i,
    input  logic                 dcm_locked_i,
    input  logic                 ddr2_calib_done_i,
    input  logic [NUM_CORES-1:0] core_hold_i,
    output logic                 ddr2_rst_o,
    output logic                 wb_rst_o,
    output logic [NUM_CORES-1:0] cpu_rst_o,
    output logic                 ready_o,
    output logic                 calib_timeout_o
);

    localparam int unsigned IdxW  = $clog2(NUM_CORES + 1);
    localparam int unsigned SyncW = NUM_CORES + 3;

    localparam logic [15:0]     LockTerm  = 16'(LOCK_STABLE_CYCLES - 1);
    localparam logic [15:0]     CalibTerm = 16'(CALIB_TIMEOUT - 1);
    localparam logic [15:0]     StageTerm = 16'(STAGE_DELAY - 1);
    localparam logic [IdxW-1:0] LastIdx   = IdxW'(NUM_CORES - 1);

    typedef enum logic [2:0] {
        StLockWait,
        StCalibWait,
        StWbRel,
        StCpuRel,
        StRun
    } state_e;

    state_e                 state_q, state_d;
    logic [15:0]            cnt_q, cnt_d;
    logic [IdxW-1:0]        idx_q, idx_d;
    logic [IdxW-1:0]        idx_inc;
    logic                   ddr2_rst_q, ddr2_rst_d;
    logic                   wb_rst_q, wb_rst_d;
    logic [NUM_CORES-1:0]   cpu_rst_q, cpu_rst_d;
    logic                   ready_q, ready_d;
    logic                   timeout_q, timeout_d;

    logic [1:0]             rst_sync_q;
    logic [SyncW-1:0]       meta_q, sync_q;
    logic [SyncW-1:0]       async_in;

    logic                   locks_ok;
    logic                   calib_ok;
    logic [NUM_CORES-1:0]   hold_s;

    assign async_in = {core_hold_i, ddr2_calib_done_i, dcm_locked_i, pll_locked_i};
    assign locks_ok = sync_q[0] & sync_q[1];
    assign calib_ok = sync_q[2];
    assign hold_s   = sync_q[SyncW-1:3];
    assign idx_inc  = idx_q + IdxW'(1);

    // FSM state only advances once the released reset has crossed two flops.
    always_ff @(posedge wb_clk_i or negedge async_rst_n_i) begin
        if (!async_rst_n_i) begin
            rst_sync_q <= '0;
            meta_q     <= '0;
            sync_q     <= '0;
            state_q    <= StLockWait;
            cnt_q      <= '0;
            idx_q      <= '0;
            ddr2_rst_q <= 1'b1;
            wb_rst_q   <= 1'b1;
            cpu_rst_q  <= '1;
            ready_q    <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
            meta_q     <= async_in;
            sync_q     <= meta_q;
            if (rst_sync_q[1]) begin
                state_q    <= state_d;
                cnt_q      <= cnt_d;
                idx_q      <= idx_d;
                ddr2_rst_q <= ddr2_rst_d;
                wb_rst_q   <= wb_rst_d;
                cpu_rst_q  <= cpu_rst_d;
                ready_q    <= ready_d;
                timeout_q  <= timeout_d;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        ddr2_rst_d = ddr2_rst_q;
        wb_rst_d   = wb_rst_q;
        cpu_rst_d  = cpu_rst_q;
        ready_d    = ready_q;
        timeout_d  = timeout_q;

        unique case (state_q)
            StLockWait: begin
                if (!locks_ok) begin
                    cnt_d = '0;
                end else if (cnt_q == LockTerm) begin
                    state_d    = StCalibWait;
                    cnt_d      = '0;
                    ddr2_rst_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StCalibWait: begin
                if (calib_ok) begin
                    state_d  = StWbRel;
                    cnt_d    = '0;
                    wb_rst_d = 1'b0;
                end else if (cnt_q == CalibTerm) begin
                    state_d    = StLockWait;
                    cnt_d      = '0;
                    ddr2_rst_d = 1'b1;
                    timeout_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StWbRel: begin
                // Core 0 is handled on the same edge that enters the core stage.
                if (cnt_q == StageTerm) begin
                    state_d      = StCpuRel;
                    cnt_d        = '0;
                    idx_d        = '0;
                    cpu_rst_d[0] = hold_s[0];
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StCpuRel: begin
                if (cnt_q == StageTerm) begin
                    cnt_d = '0;
                    if (idx_q == LastIdx) begin
                        state_d = StRun;
                        ready_d = 1'b1;
                    end else begin
                        idx_d = idx_inc;
                        for (int i = 0; i < int'(NUM_CORES); i++) begin
                            if (idx_inc == IdxW'(i)) begin
                                cpu_rst_d[i] = hold_s[i];
                            end
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StRun: begin
                cnt_d     = '0;
                cpu_rst_d = hold_s;
            end
            default: begin
                state_d = StLockWait;
            end
        endcase

        // Losing either clock lock outranks every other transition.
        if ((state_q != StLockWait) && !locks_ok) begin
            state_d    = StLockWait;
            cnt_d      = '0;
            idx_d      = '0;
            ddr2_rst_d = 1'b1;
            wb_rst_d   = 1'b1;
            cpu_rst_d  = '1;
            ready_d    = 1'b0;
            timeout_d  = timeout_q;
        end
    end

    assign ddr2_rst_o      = ddr2_rst_q;
    assign wb_rst_o        = wb_rst_q;
    assign cpu_rst_o       = cpu_rst_q;
    assign ready_o         = ready_q;
    assign calib_timeout_o = timeout_q;

endmodule

// File: tb/tb_rst_seq.sv
// Directed bench for rst_seq: expected output changes (cycle and value) are queued
// as stimulus is applied and checked against the next observed output change.
module tb_rst_seq;

    logic       clk;
    logic       rst_n;
    logic       pll;
    logic       dcm;
    logic       calib;
    logic [1:0] hold;
    logic       ddr2_rst;
    logic       wb_rst;
    logic [1:0] cpu_rst;
    logic       ready;
    logic       tmo;
    logic [5:0] outv;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        string      tag;
        int         at;
        logic [5:0] val;
    } exp_t;

    exp_t       sb[$];
    logic [5:0] last_out;
    int         mark;

    rst_seq #(
        .NUM_CORES         (2),
        .LOCK_STABLE_CYCLES(8),
        .STAGE_DELAY       (4),
        .CALIB_TIMEOUT     (32)
    ) dut (
        .wb_clk_i         (clk),
        .async_rst_n_i    (rst_n),
        .pll_locked_i     (pll),
        .dcm_locked_i     (dcm),
        .ddr2_calib_done_i(calib),
        .core_hold_i      (hold),
        .ddr2_rst_o       (ddr2_rst),
        .wb_rst_o         (wb_rst),
        .cpu_rst_o        (cpu_rst),
        .ready_o          (ready),
        .calib_timeout_o  (tmo)
    );

    // {ddr2, wb, cpu[1], cpu[0], ready, timeout}
    assign outv = {ddr2_rst, wb_rst, cpu_rst[1], cpu_rst[0], ready, tmo};

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic push(input string tag, input int at, input logic [5:0] val);
        exp_t e;
        e.tag = tag;
        e.at  = at;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Wait for the next output change and compare its cycle and value.
    task automatic check_next();
        exp_t e;
        bit   seen;
        e    = sb.pop_front();
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (outv !== last_out) seen = 1'b1;
        end
        checks++;
        assert (seen && (cyc === e.at)) else begin
            errors++;
            $error("FAIL %s timing: change seen=%0d at cyc %0d, expected cyc %0d",
                   e.tag, seen, cyc, e.at);
        end
        checks++;
        assert (outv === e.val) else begin
            errors++;
            $error("FAIL %s value: got %b, expected %b", e.tag, outv, e.val);
        end
        last_out = outv;
    endtask

    task automatic check_now(input string tag, input logic [5:0] val);
        checks++;
        assert (outv === val) else begin
            errors++;
            $error("FAIL %s: got %b, expected %b", tag, outv, val);
        end
        last_out = outv;
    endtask

    initial begin
        rst_n = 1'b0;
        pll   = 1'b0;
        dcm   = 1'b0;
        calib = 1'b0;
        hold  = 2'b00;
        idle(3);
        check_now("reset", 6'b111100);

        // Nominal sequence.
        rst_n = 1'b1;
        idle(4);
        pll = 1'b1;
        dcm = 1'b1;
        push("t1_ddr2", cyc + 10, 6'b011100);
        check_next();
        idle(5);
        calib = 1'b1;
        push("t1_wb", cyc + 3, 6'b001100);
        check_next();
        mark = cyc;
        push("t1_cpu0", mark + 4, 6'b001000);
        push("t1_cpu1", mark + 8, 6'b000000);
        push("t1_ready", mark + 12, 6'b000010);
        repeat (3) check_next();

        // Lock loss in RUN, then full repeat after relock.
        idle(3);
        dcm = 1'b0;
        push("t5_drop", cyc + 3, 6'b111100);
        check_next();
        idle(3);
        dcm = 1'b1;
        push("t5_ddr2", cyc + 10, 6'b011100);
        check_next();
        push("t5_wb", cyc + 1, 6'b001100);
        check_next();
        mark = cyc;
        push("t5_cpu0", mark + 4, 6'b001000);
        push("t5_cpu1", mark + 8, 6'b000000);
        push("t5_ready", mark + 12, 6'b000010);
        repeat (3) check_next();

        // Reset, then a one-cycle PLL glitch at lock count 5.
        rst_n = 1'b0;
        pll   = 1'b0;
        dcm   = 1'b0;
        calib = 1'b0;
        #1;
        check_now("rst_async1", 6'b111100);
        @(negedge clk);
        rst_n = 1'b1;
        idle(4);
        pll = 1'b1;
        dcm = 1'b1;
        mark = cyc;
        idle(7);
        pll = 1'b0;
        idle(1);
        pll = 1'b1;
        push("t2_ddr2", mark + 18, 6'b011100);
        check_next();

        // Calibration never completes: timeout, retry, then late calibration.
        mark = cyc;
        push("t3_timeout", mark + 32, 6'b111101);
        push("t3_retry", mark + 40, 6'b011101);
        repeat (2) check_next();
        calib = 1'b1;
        push("t3_wb", cyc + 3, 6'b001101);
        check_next();
        mark = cyc;
        push("t3_cpu0", mark + 4, 6'b001001);
        push("t3_cpu1", mark + 8, 6'b000001);
        push("t3_ready", mark + 12, 6'b000011);
        repeat (3) check_next();

        // Relock into CPU_REL, then an async reset pulse clears the timeout flag.
        idle(2);
        dcm = 1'b0;
        push("t6_drop", cyc + 3, 6'b111101);
        check_next();
        idle(2);
        dcm = 1'b1;
        push("t6_ddr2", cyc + 10, 6'b011101);
        check_next();
        push("t6_wb", cyc + 1, 6'b001101);
        check_next();
        push("t6_cpu0", cyc + 4, 6'b001001);
        check_next();
        idle(1);
        #2;
        hold  = 2'b10;
        rst_n = 1'b0;
        #1;
        check_now("rst_async2", 6'b111100);

        // Core 1 held through the sequence, then released in RUN.
        @(negedge clk);
        rst_n = 1'b1;
        push("t4_ddr2", cyc + 10, 6'b011100);
        check_next();
        push("t4_wb", cyc + 1, 6'b001100);
        check_next();
        mark = cyc;
        push("t4_cpu0", mark + 4, 6'b001000);
        push("t4_ready", mark + 12, 6'b001010);
        repeat (2) check_next();
        idle(2);
        hold = 2'b00;
        push("t4_unhold", cyc + 3, 6'b000010);
        check_next();

        idle(3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
